// File: rtl/counter_core_pkg.sv
// counter_core_pkg: shared types and helpers for multi_channel_counter_core.
//   mode_t     : channel run mode (wrap / one-shot)
//   chan_cfg_t : packed per-channel configuration {en, dir, ire, mode}
//   ch_idx_w() : channel-select width, never below 1 bit
package counter_core_pkg;

  typedef enum logic {
    MODE_WRAP    = 1'b0,
    MODE_ONESHOT = 1'b1
  } mode_t;

  typedef struct packed {
    logic  en;
    logic  dir;   // 1 = up, 0 = down
    logic  ire;
    mode_t mode;
  } chan_cfg_t;

  localparam chan_cfg_t CFG_RST = '{en: 1'b0, dir: 1'b0, ire: 1'b0, mode: MODE_WRAP};

  function automatic int ch_idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/counter_channel.sv
// counter_channel: one up/down counter channel.
//   Holds count, compare, config and lt status; reports a match when the
//   registered count equals compare while enabled. One-shot channels stop
//   (en cleared, count held) on the match edge.
// Ports:
//   clk, reset_n              clock, async active-low reset
//   sel                       this channel is addressed by the register port
//   count_we/count_in         count load
//   config_we/cfg_in          config load
//   compare_we/compare_in     compare load
//   presc_we/presc_in/presc   prescale register (PRESCALER_EN builds only)
//   count, compare, cfg, lt   registered state
//   match                     combinational match flag
// Build option: `define PRESCALER_EN adds a per-channel prescaler.
module counter_channel
  import counter_core_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int LT_THRESHOLD = 1000
`ifdef PRESCALER_EN
  , parameter int PRESC_WIDTH = 8
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sel,
  input  logic             count_we,
  input  logic [WIDTH-1:0] count_in,
  input  logic             config_we,
  input  chan_cfg_t        cfg_in,
  input  logic             compare_we,
  input  logic [WIDTH-1:0] compare_in,
`ifdef PRESCALER_EN
  input  logic                   presc_we,
  input  logic [PRESC_WIDTH-1:0] presc_in,
  output logic [PRESC_WIDTH-1:0] presc,
`endif
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] compare,
  output chan_cfg_t        cfg,
  output logic             lt,
  output logic             match
);

  localparam logic LT_RST = (LT_THRESHOLD > 0);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] compare_q, compare_d;
  chan_cfg_t        cfg_q, cfg_d;
  logic             lt_q, lt_d;
  logic             tick;
  logic             oneshot_stop;

`ifdef PRESCALER_EN
  logic [PRESC_WIDTH-1:0] presc_q, presc_d;
  logic [PRESC_WIDTH-1:0] tick_q, tick_d;

  assign tick = (tick_q == presc_q);

  // Tick counter only advances while enabled; any count/presc write restarts it.
  always_comb begin
    presc_d = presc_q;
    tick_d  = tick_q;
    if (sel && (count_we || presc_we)) tick_d = '0;
    else if (cfg_q.en)                 tick_d = tick ? '0 : tick_q + PRESC_WIDTH'(1);
    if (sel && presc_we) presc_d = presc_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      tick_q  <= '0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  assign presc = presc_q;
`else
  assign tick = 1'b1;
`endif

  assign match        = cfg_q.en && (count_q == compare_q);
  assign oneshot_stop = match && (cfg_q.mode == MODE_ONESHOT);

  always_comb begin
    count_d   = count_q;
    compare_d = compare_q;
    cfg_d     = cfg_q;
    // Compared at 64 bits so thresholds wider than the counter still work.
    lt_d      = (LT_THRESHOLD > 0) && (64'(count_q) < 64'(LT_THRESHOLD));

    if (sel && count_we)      count_d = count_in;
    else if (oneshot_stop)    count_d = count_q;
    else if (cfg_q.en && tick) count_d = cfg_q.dir ? count_q + WIDTH'(1) : count_q - WIDTH'(1);

    // A register write overrides the internal one-shot stop.
    if (oneshot_stop)          cfg_d.en  = 1'b0;
    if (sel && config_we)      cfg_d     = cfg_in;
    if (sel && compare_we)     compare_d = compare_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q   <= '0;
      compare_q <= '1;
      cfg_q     <= CFG_RST;
      lt_q      <= LT_RST;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      cfg_q     <= cfg_d;
      lt_q      <= lt_d;
    end
  end

  assign count   = count_q;
  assign compare = compare_q;
  assign cfg     = cfg_q;
  assign lt      = lt_q;

endmodule

// File: rtl/multi_channel_counter_core.sv
// multi_channel_counter_core: NUM_CH independent up/down counters behind one
// register port with channel select, sticky match status (write-1-to-clear)
// and a registered shared interrupt.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   ch_sel                       channel for all *_we strobes and *_out reads
//   count_we/count_in            count load
//   config_we/en,dir,ire,mode_in config load
//   compare_we/compare_in        compare load
//   irq_clr_we/irq_clr_in        status clear mask
//   count_out..lt_out            selected channel view (zeros if out of range)
//   irq_status, irq_out          sticky flags, level interrupt
// Build option: `define PRESCALER_EN adds PRESC_WIDTH and presc_we/presc_in/presc_out.
module multi_channel_counter_core
  import counter_core_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int WIDTH        = 32,
  parameter int LT_THRESHOLD = 1000
`ifdef PRESCALER_EN
  , parameter int PRESC_WIDTH = 8
`endif
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [ch_idx_w(NUM_CH)-1:0] ch_sel,
  input  logic                        count_we,
  input  logic [WIDTH-1:0]            count_in,
  input  logic                        config_we,
  input  logic                        en_in,
  input  logic                        dir_in,
  input  logic                        ire_in,
  input  logic                        mode_in,
  input  logic                        compare_we,
  input  logic [WIDTH-1:0]            compare_in,
  input  logic                        irq_clr_we,
  input  logic [NUM_CH-1:0]           irq_clr_in,
`ifdef PRESCALER_EN
  input  logic                        presc_we,
  input  logic [PRESC_WIDTH-1:0]      presc_in,
  output logic [PRESC_WIDTH-1:0]      presc_out,
`endif
  output logic [WIDTH-1:0]            count_out,
  output logic [WIDTH-1:0]            compare_out,
  output logic                        en_out,
  output logic                        dir_out,
  output logic                        ire_out,
  output logic                        mode_out,
  output logic                        lt_out,
  output logic [NUM_CH-1:0]           irq_status,
  output logic                        irq_out
);

  localparam int CH_W = ch_idx_w(NUM_CH);

  chan_cfg_t                     cfg_in;
  logic [NUM_CH-1:0]             sel_vec;
  logic [NUM_CH-1:0][WIDTH-1:0]  cnt_vec, cmp_vec;
  chan_cfg_t [NUM_CH-1:0]        cfg_vec;
  logic [NUM_CH-1:0]             lt_vec, match_vec, ire_vec;
`ifdef PRESCALER_EN
  logic [NUM_CH-1:0][PRESC_WIDTH-1:0] presc_vec;
`endif

  logic [NUM_CH-1:0] irq_status_q, irq_status_d;
  logic              irq_q, irq_d;

  assign cfg_in = '{en: en_in, dir: dir_in, ire: ire_in, mode: mode_t'(mode_in)};

  // Out-of-range selects decode to no channel, so their writes are dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign sel_vec[i] = (ch_sel == CH_W'(i));
    assign ire_vec[i] = cfg_vec[i].ire;

    counter_channel #(
      .WIDTH        (WIDTH),
      .LT_THRESHOLD (LT_THRESHOLD)
`ifdef PRESCALER_EN
      , .PRESC_WIDTH(PRESC_WIDTH)
`endif
    ) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .sel        (sel_vec[i]),
      .count_we   (count_we),
      .count_in   (count_in),
      .config_we  (config_we),
      .cfg_in     (cfg_in),
      .compare_we (compare_we),
      .compare_in (compare_in),
`ifdef PRESCALER_EN
      .presc_we   (presc_we),
      .presc_in   (presc_in),
      .presc      (presc_vec[i]),
`endif
      .count      (cnt_vec[i]),
      .compare    (cmp_vec[i]),
      .cfg        (cfg_vec[i]),
      .lt         (lt_vec[i]),
      .match      (match_vec[i])
    );
  end

  always_comb begin
    count_out   = '0;
    compare_out = '0;
    en_out      = 1'b0;
    dir_out     = 1'b0;
    ire_out     = 1'b0;
    mode_out    = 1'b0;
    lt_out      = 1'b0;
`ifdef PRESCALER_EN
    presc_out   = '0;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_vec[i]) begin
        count_out   = cnt_vec[i];
        compare_out = cmp_vec[i];
        en_out      = cfg_vec[i].en;
        dir_out     = cfg_vec[i].dir;
        ire_out     = cfg_vec[i].ire;
        mode_out    = cfg_vec[i].mode;
        lt_out      = lt_vec[i];
`ifdef PRESCALER_EN
        presc_out   = presc_vec[i];
`endif
      end
    end
  end

  // New matches are OR'd in after the clear so a same-cycle set wins.
  always_comb begin
    irq_status_d = (irq_status_q & ~(irq_clr_we ? irq_clr_in : '0)) | match_vec;
    irq_d        = |(irq_status_q & ire_vec);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_status_q <= '0;
      irq_q        <= 1'b0;
    end else begin
      irq_status_q <= irq_status_d;
      irq_q        <= irq_d;
    end
  end

  assign irq_status = irq_status_q;
  assign irq_out    = irq_q;

endmodule

// File: tb/tb_multi_channel_counter_core.sv
module tb_multi_channel_counter_core;
  localparam int NCH = 5;   // 5 channels so ch_sel 5..7 are out of range
  localparam int W   = 8;
  localparam int LT  = 1000;
  localparam int CW  = 3;
  localparam int PW  = 8;

  logic clk = 1'b0, reset_n = 1'b0;
  logic [CW-1:0]  ch_sel;
  logic           count_we, config_we, compare_we, irq_clr_we;
  logic [W-1:0]   count_in, compare_in;
  logic           en_in, dir_in, ire_in, mode_in;
  logic [NCH-1:0] irq_clr_in;
  logic [W-1:0]   count_out, compare_out;
  logic           en_out, dir_out, ire_out, mode_out, lt_out, irq_out;
  logic [NCH-1:0] irq_status;
  logic           presc_we;
  logic [PW-1:0]  presc_in, presc_rd;

  always #5 clk = ~clk;

  multi_channel_counter_core #(.NUM_CH(NCH), .WIDTH(W), .LT_THRESHOLD(LT)
`ifdef PRESCALER_EN
    , .PRESC_WIDTH(PW)
`endif
  ) dut (
    .clk(clk), .reset_n(reset_n), .ch_sel(ch_sel),
    .count_we(count_we), .count_in(count_in),
    .config_we(config_we), .en_in(en_in), .dir_in(dir_in), .ire_in(ire_in), .mode_in(mode_in),
    .compare_we(compare_we), .compare_in(compare_in),
    .irq_clr_we(irq_clr_we), .irq_clr_in(irq_clr_in),
`ifdef PRESCALER_EN
    .presc_we(presc_we), .presc_in(presc_in), .presc_out(presc_rd),
`endif
    .count_out(count_out), .compare_out(compare_out),
    .en_out(en_out), .dir_out(dir_out), .ire_out(ire_out), .mode_out(mode_out),
    .lt_out(lt_out), .irq_status(irq_status), .irq_out(irq_out)
  );

`ifndef PRESCALER_EN
  assign presc_rd = '0;
`endif

  typedef struct {
    logic [W-1:0]   cnt, cmp;
    logic           en, dir, ire, mode, lt;
    logic [NCH-1:0] st;
    logic           irq;
    logic [PW-1:0]  pr;
  } exp_t;

  exp_t q[$];
  int n_chk = 0, n_pass = 0;

  // Reference model: plain per-channel arrays updated once per clock edge.
  int m_cnt[NCH], m_cmp[NCH], m_pr[NCH], m_tk[NCH];
  bit m_en[NCH], m_dir[NCH], m_ire[NCH], m_mode[NCH], m_lt[NCH];
  bit [NCH-1:0] m_st;
  bit m_irq;

  function automatic void m_reset();
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i] = 0; m_cmp[i] = (1 << W) - 1; m_pr[i] = 0; m_tk[i] = 0;
      m_en[i] = 0; m_dir[i] = 0; m_ire[i] = 0; m_mode[i] = 0; m_lt[i] = (LT > 0);
    end
    m_st = '0; m_irq = 0;
  endfunction

  function automatic void m_step();
    bit [NCH-1:0] hit;
    bit irq_n, s, tk;
    irq_n = 0;
    for (int i = 0; i < NCH; i++) begin
      hit[i] = m_en[i] && (m_cnt[i] == m_cmp[i]);
      if (m_st[i] && m_ire[i]) irq_n = 1;
    end
    for (int i = 0; i < NCH; i++) begin
      s  = (int'(ch_sel) == i);
      tk = 1;
`ifdef PRESCALER_EN
      tk = (m_tk[i] == m_pr[i]);
      if (s && (count_we || presc_we)) m_tk[i] = 0;
      else if (m_en[i])                m_tk[i] = tk ? 0 : m_tk[i] + 1;
      if (s && presc_we) m_pr[i] = int'(presc_in);
`endif
      m_lt[i] = m_cnt[i] < LT;
      if (s && count_we)            m_cnt[i] = int'(count_in);
      else if (hit[i] && m_mode[i]) m_cnt[i] = m_cnt[i];
      else if (m_en[i] && tk)       m_cnt[i] = (m_cnt[i] + (m_dir[i] ? 1 : (1 << W) - 1)) % (1 << W);
      if (hit[i] && m_mode[i]) m_en[i] = 0;
      if (s && config_we) begin
        m_en[i] = en_in; m_dir[i] = dir_in; m_ire[i] = ire_in; m_mode[i] = mode_in;
      end
      if (s && compare_we) m_cmp[i] = int'(compare_in);
    end
    m_st  = (m_st & ~(irq_clr_we ? irq_clr_in : '0)) | hit;
    m_irq = irq_n;
  endfunction

  function automatic exp_t m_read();
    exp_t e;
    int   c;
    c = int'(ch_sel);
    e = '{cnt: '0, cmp: '0, en: 0, dir: 0, ire: 0, mode: 0, lt: 0, st: m_st, irq: m_irq, pr: '0};
    if (c < NCH) begin
      e.cnt = W'(m_cnt[c]); e.cmp = W'(m_cmp[c]);
      e.en = m_en[c]; e.dir = m_dir[c]; e.ire = m_ire[c]; e.mode = m_mode[c]; e.lt = m_lt[c];
`ifdef PRESCALER_EN
      e.pr = PW'(m_pr[c]);
`endif
    end
    return e;
  endfunction

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endfunction

  // Monitor: compares the DUT view against the oldest queued expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("count_out",   64'(count_out),   64'(e.cnt));
      chk("compare_out", 64'(compare_out), 64'(e.cmp));
      chk("en_out",      64'(en_out),      64'(e.en));
      chk("dir_out",     64'(dir_out),     64'(e.dir));
      chk("ire_out",     64'(ire_out),     64'(e.ire));
      chk("mode_out",    64'(mode_out),    64'(e.mode));
      chk("lt_out",      64'(lt_out),      64'(e.lt));
      chk("irq_status",  64'(irq_status),  64'(e.st));
      chk("irq_out",     64'(irq_out),     64'(e.irq));
      chk("presc_out",   64'(presc_rd),    64'(e.pr));
    end
  end

  // One cycle: inputs already set; queue the view expected now, then take the edge.
  task automatic cyc();
    if (!reset_n) m_reset();
    q.push_back(m_read());
    @(posedge clk);
    if (reset_n) m_step();
    #1;
  endtask

  task automatic idle(input int sel, input int n);
    count_we = 0; config_we = 0; compare_we = 0; irq_clr_we = 0; presc_we = 0;
    ch_sel = CW'(sel);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic setup(input int sel, input int cnt, input bit en, input bit dir,
                       input bit ire, input bit mode, input int cmp);
    idle(sel, 0);
    count_we = 1; count_in = W'(cnt);
    config_we = 1; en_in = en; dir_in = dir; ire_in = ire; mode_in = mode;
    compare_we = 1; compare_in = W'(cmp);
    cyc();
  endtask

  initial begin
    ch_sel = '0; count_we = 0; config_we = 0; compare_we = 0; irq_clr_we = 0;
    count_in = '0; compare_in = '0; en_in = 0; dir_in = 0; ire_in = 0; mode_in = 0;
    irq_clr_in = '0; presc_we = 0; presc_in = '0;
    m_reset();
    @(posedge clk); #1;
    idle(0, 3);                       // reset state while held
    reset_n = 1;
    idle(0, 2);

    setup(0, 0, 1, 1, 0, 0, 5);       // up/wrap, match at 5, ire off
    idle(0, 8);
    setup(1, 1, 1, 0, 0, 0, 200);     // down through 0 -> 255
    idle(1, 4);
    setup(2, 0, 1, 1, 1, 1, 3);       // one-shot, ire on
    idle(2, 6);
    irq_clr_we = 1; irq_clr_in = NCH'(5'b00100); cyc();
    idle(2, 3);
    setup(3, 7, 1, 1, 0, 0, 7);       // matches on the very next cycle
    irq_clr_we = 1; irq_clr_in = NCH'(5'b01000); cyc();   // set beats clear
    idle(3, 2);
    count_we = 1; count_in = W'(100); cyc();              // load beats count
    idle(3, 2);
    setup(5, 33, 1, 1, 1, 1, 44);     // out of range: ignored, reads zero
    idle(6, 1); idle(7, 1); idle(3, 1);
`ifdef PRESCALER_EN
    setup(4, 0, 1, 1, 0, 0, 250);
    presc_we = 1; presc_in = PW'(2); cyc();
    idle(4, 30);
`endif
    reset_n = 0; idle(0, 1);          // mid-run async reset
    reset_n = 1; idle(0, 1);

    for (int k = 0; k < 1500; k++) begin
      ch_sel     = CW'($urandom_range(0, 6));
      count_we   = ($urandom_range(0, 5) == 0);
      count_in   = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 12));
      config_we  = ($urandom_range(0, 4) == 0);
      en_in      = ($urandom_range(0, 3) != 0);
      dir_in     = 1'($urandom);
      ire_in     = 1'($urandom);
      mode_in    = 1'($urandom);
      compare_we = ($urandom_range(0, 5) == 0);
      compare_in = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 12));
      irq_clr_we = ($urandom_range(0, 5) == 0);
      irq_clr_in = NCH'($urandom);
      presc_we   = ($urandom_range(0, 9) == 0);
      presc_in   = PW'($urandom_range(0, 3));
      reset_n    = ($urandom_range(0, 299) != 0);
      cyc();
      reset_n    = 1;
    end
    idle(0, 2);
    @(negedge clk); #1;
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/multi_channel_counter_core.md
Name: multi_channel_counter_core

Overview:
- Parametrised successor to the single up/down counter peripheral core.
- Provides NUM_CH independent up/down counters of WIDTH bits, shared by one register port with a channel select.
- Adds per-channel compare match, one-shot/wrap modes, sticky interrupt status with write-1-to-clear, and a shared interrupt line.
- Sits behind the peripheral native register interface; irq_out goes to the system interrupt controller.

Parameters:
- NUM_CH, 4, number of counter channels (1..16).
- WIDTH, 32, counter and compare width in bits (8..64).
- LT_THRESHOLD, 1000, per-channel lt status is set when count < LT_THRESHOLD.

Ports:
- clk  in  1  peripheral clock.
- reset_n  in  1  asynchronous active-low reset.
- ch_sel  in  $clog2(NUM_CH) (min 1)  channel addressed by all *_we strobes and *_out reads.
- count_we  in  1  load count_in into the selected channel.
- count_in  in  WIDTH  count load value.
- config_we  in  1  load en/dir/ire/mode into the selected channel.
- en_in, dir_in, ire_in, mode_in  in  1 each  enable; 1=up/0=down; interrupt enable; 0=wrap/1=one-shot.
- compare_we  in  1  load compare_in into the selected channel.
- compare_in  in  WIDTH  compare value.
- irq_clr_we  in  1  write-1-to-clear strobe for irq_status.
- irq_clr_in  in  NUM_CH  bitmask of status bits to clear.
- count_out  out  WIDTH  selected channel count.
- compare_out  out  WIDTH  selected channel compare.
- en_out, dir_out, ire_out, mode_out, lt_out  out  1 each  selected channel config and status.
- irq_status  out  NUM_CH  sticky match flags, all channels.
- irq_out  out  1  registered interrupt request.

Behaviour:
- Reset (reset_n low, async): all counts 0, compares all-ones, en/dir/ire/mode 0, lt 1 if LT_THRESHOLD>0, irq_status 0, irq_out 0.
- Outputs are a combinational mux of registered state by ch_sel, with zero read latency. An out-of-range ch_sel reads all zeros, and its writes are ignored.
- Count per channel, per cycle:
  - count_we wins over counting.
  - Otherwise, if en, count ±1 modulo 2^WIDTH (wrap 2^WIDTH-1 ↔ 0).
- Match: a channel matches when its registered count == compare and en=1. A match sets irq_status[i] on the next edge.
- One-shot mode: on match, en clears on the same edge the status sets, and count holds at the compare value.
- Wrap mode: counting continues through the match.
- config_we and an internal one-shot en-clear in the same cycle: config_we wins.
- Same-cycle set and clear of a status bit: set wins.
- lt[i] is registered: count < LT_THRESHOLD, evaluated on the current count, so it lags by one cycle.
- irq_out is registered: |(irq_status & ire). It stays asserted until the status is cleared or ire is dropped. This replaces the previous single-cycle pulse behaviour.
- Writes to different registers in the same cycle (count_we, config_we, compare_we) all take effect.
- Reset asserted mid-count returns to reset values immediately. There is no pending state.

Optional Feature:
- Macro PRESCALER_EN.
- Defined:
  - Adds parameter PRESC_WIDTH (default 8).
  - Adds ports presc_we (in, 1), presc_in (in, PRESC_WIDTH) and presc_out (out, PRESC_WIDTH).
  - Each channel gets a prescale register (reset 0) and a tick counter. The channel counts only when the tick counter reaches presc, i.e. every presc+1 cycles.
  - count_we or presc_we on a channel resets its tick counter to 0.
  - Match detection is unchanged.
- Undefined: the ports and parameter are absent, and channels count every enabled cycle.

Decomposition:
- Package counter_core_pkg holds:
  - typedef mode_t enum {MODE_WRAP=0, MODE_ONESHOT=1};
  - a chan_cfg_t struct packing en, dir, ire, mode;
  - function ch_idx_w(n) returning max(1, $clog2(n)).
- Sub-module counter_channel contains one channel's count, compare, config, lt, match and the optional prescaler.
- The top generates NUM_CH instances and holds the select decode, read mux, irq_status and irq_out.

Test Plan:
- Reset, then ch 0 set to up/wrap/en, count=0, compare=5 → count_out 5 after 5 cycles; irq_status[0]=1 the next edge; irq_out=0 while ire=0.
- WIDTH=8 ch 1 down/en from count 1 → sequence 1, 0, 255; lt_out 1 throughout with LT_THRESHOLD=1000.
- Ch 2 one-shot, up, ire=1, compare=3 → en_out drops on the match edge, count holds 3, irq_out=1 the following cycle; irq_clr 0b0100 → irq_out 0 a cycle later.
- A match and irq_clr_in targeting the same bit in the same cycle → the bit remains 1.
- count_we=100 while en=1 on ch 3 → count_out=100 the next cycle, not 101; ch_sel=NUM_CH writes → no state change, reads 0.
- PRESCALER_EN, presc=2, up from 0 → count increments every 3 cycles: 30 cycles give 10.
